// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the HI/LO multiply/divide unit.
//   op_e    : opcode encodings driven on muldiv_unit.op
//   state_e : sequencer states of muldiv_unit
//   DIV0_QUOTIENT : quotient returned on divide by zero (all ones, sliced to WIDTH)
//   op_is_div / op_is_signed : opcode decode helpers
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Held at 64 bits so any WIDTH up to 64 can take the low slice.
  localparam int          DIV0_QUOTIENT_W = 64;
  localparam logic [63:0] DIV0_QUOTIENT   = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic op_is_div(input logic [1:0] op_v);
    return (op_v == OP_DIV) || (op_v == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op_v);
    return (op_v == OP_MULT) || (op_v == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: sign handling around the unsigned multiply/divide core.
//   Entry side (combinational on the launch operands):
//     sgn, a, b        -> a_mag, b_mag : magnitudes (pass-through when sgn=0)
//                      -> neg_res      : result/quotient must be negated
//                      -> neg_rem      : remainder must be negated (dividend sign)
//   Exit side (combinational on the raw unsigned result):
//     is_div, fix_res, fix_rem, raw -> fixed
//       multiply: whole 2*WIDTH product negated when fix_res
//       divide  : upper half (remainder) by fix_rem, lower half (quotient) by fix_res
module muldiv_signfix import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     a_mag,
  output logic [WIDTH-1:0]     b_mag,
  output logic                 neg_res,
  output logic                 neg_rem,
  input  logic                 is_div,
  input  logic                 fix_res,
  input  logic                 fix_rem,
  input  logic [2*WIDTH-1:0]   raw,
  output logic [2*WIDTH-1:0]   fixed
);

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Magnitude of signed operands; the most negative value maps onto 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag   = a;
    b_mag   = b;
    neg_res = 1'b0;
    neg_rem = 1'b0;
    if (sgn) begin
      if (a[WIDTH-1]) begin
        a_mag = (~a) + ONE_W;
      end else begin
        a_mag = a;
      end
      if (b[WIDTH-1]) begin
        b_mag = (~b) + ONE_W;
      end else begin
        b_mag = b;
      end
      neg_res = a[WIDTH-1] ^ b[WIDTH-1];
      neg_rem = a[WIDTH-1];
    end else begin
      neg_res = 1'b0;
      neg_rem = 1'b0;
    end
  end

  // Re-apply signs to the unsigned result.
  always_comb begin
    fixed = raw;
    if (is_div) begin
      if (fix_rem) begin
        fixed[2*WIDTH-1:WIDTH] = (~raw[2*WIDTH-1:WIDTH]) + ONE_W;
      end else begin
        fixed[2*WIDTH-1:WIDTH] = raw[2*WIDTH-1:WIDTH];
      end
      if (fix_res) begin
        fixed[WIDTH-1:0] = (~raw[WIDTH-1:0]) + ONE_W;
      end else begin
        fixed[WIDTH-1:0] = raw[WIDTH-1:0];
      end
    end else begin
      if (fix_res) begin
        fixed = (~raw) + ONE_2W;
      end else begin
        fixed = raw;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU,
// MFHI/MFLO via the hi/lo outputs, MTHI/MTLO via we_hi/we_lo).
//   clk, reset        : clock, synchronous active-high reset
//   start, op, a, b   : launch an operation (accepted only in IDLE)
//   we_hi, we_lo, wdata : MTHI/MTLO writes (accepted only in IDLE)
//   busy, done        : operation in flight / one-cycle completion pulse
//   hi, lo            : HI and LO registers
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in a single
// cycle (IDLE -> FINISH); divides stay iterative.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

  state_e               state_r;
  logic [1:0]           op_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     opnd_r;
  logic [WIDTH-1:0]     a_raw_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 neg_res_r;
  logic                 neg_rem_r;
  logic                 div0_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 in_div_s;
  logic                 in_signed_s;
  logic                 run_div_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic                 neg_res_s;
  logic                 neg_rem_s;
  logic [2*WIDTH-1:0]   fixed_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_trial_s;
  logic [WIDTH:0]       div_diff_s;
  logic [2*WIDTH-1:0]   acc_next_s;
  logic [WIDTH-1:0]     res_hi_s;
  logic [WIDTH-1:0]     res_lo_s;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0]   fast_prod_s;
`endif

  assign in_div_s    = op_is_div(op);
  assign in_signed_s = op_is_signed(op);
  assign run_div_s   = op_is_div(op_r);

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .sgn     (in_signed_s),
    .a       (a),
    .b       (b),
    .a_mag   (a_mag_s),
    .b_mag   (b_mag_s),
    .neg_res (neg_res_s),
    .neg_rem (neg_rem_s),
    .is_div  (run_div_s),
    .fix_res (neg_res_r),
    .fix_rem (neg_rem_r),
    .raw     (acc_r),
    .fixed   (fixed_s)
  );

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod_s = {{WIDTH{1'b0}}, a_mag_s} * {{WIDTH{1'b0}}, b_mag_s};
`endif

  // Multiply keeps {partial, multiplier} in acc_r; divide keeps {remainder, dividend/quotient}.
  assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
  assign div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
  assign div_diff_s  = div_trial_s - {1'b0, opnd_r};

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    acc_next_s = acc_r;
    if (run_div_s) begin
      if (!div_diff_s[WIDTH]) begin
        acc_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_r[0]) begin
        acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end else begin
        acc_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
      end
    end
  end

  // Final HI/LO values; divide by zero returns the original dividend and an all-ones quotient.
  always_comb begin
    res_hi_s = fixed_s[2*WIDTH-1:WIDTH];
    res_lo_s = fixed_s[WIDTH-1:0];
    if (div0_r) begin
      res_hi_s = a_raw_r;
      res_lo_s = DIV0_QUOTIENT[WIDTH-1:0];
    end else begin
      res_hi_s = fixed_s[2*WIDTH-1:WIDTH];
      res_lo_s = fixed_s[WIDTH-1:0];
    end
  end

  // Sequencer, iteration counter, datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'd0;
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opnd_r    <= ZERO_W;
      a_raw_r   <= ZERO_W;
      hi_r      <= ZERO_W;
      lo_r      <= ZERO_W;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (we_hi) begin
            hi_r <= wdata;
          end
          if (we_lo) begin
            lo_r <= wdata;
          end
          if (start) begin
            op_r      <= op;
            a_raw_r   <= a;
            neg_res_r <= neg_res_s;
            neg_rem_r <= neg_rem_s;
            div0_r    <= in_div_s && (b == ZERO_W);
            opnd_r    <= in_div_s ? b_mag_s : a_mag_s;
            cnt_r     <= {CNT_W{1'b0}};
            busy_r    <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            if (in_div_s) begin
              acc_r   <= {ZERO_W, a_mag_s};
              state_r <= ST_RUN;
            end else begin
              acc_r   <= fast_prod_s;
              done_r  <= 1'b1;
              state_r <= ST_FINISH;
            end
`else
            acc_r   <= {ZERO_W, (in_div_s ? a_mag_s : b_mag_s)};
            state_r <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            done_r  <= 1'b1;
            state_r <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          hi_r    <= res_hi_s;
          lo_r    <= res_lo_s;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared = 0;
  int mismatched = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles from the current one (counted as 1) until busy drops.
  task automatic wait_idle(input string tag, input int lat);
    int n = 0;
    int nd = 0;
    int done_at = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (done === 1'b1) begin
        nd++;
        done_at = n;
      end
      tick();
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(lat));
    check({tag, "_done_pulses"}, 64'(nd), 64'd1);
    check({tag, "_done_last_busy"}, 64'(done_at), 64'(lat));
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input int lat,
                       input logic [31:0] eh, input logic [31:0] el);
    op = o;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(tag, lat);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 2'd0;
    a = 32'd0;
    b = 32'd0;
    we_hi = 1'b0;
    we_lo = 1'b0;
    wdata = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_negdiv", 2'd2, 32'h0000_0007, 32'hFFFF_FFFE, DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD);
    do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0000_0000, 32'h8000_0000);
    do_op("divu_zero", 2'd3, 32'h0000_0064, 32'h0000_0000, DIV_LAT, 32'h0000_0064, 32'hFFFF_FFFF);
    do_op("div_zero", 2'd2, 32'hFFFF_FFFB, 32'h0000_0000, DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // MTHI in IDLE
    we_hi = 1'b1;
    wdata = 32'h1234_5678;
    tick();
    we_hi = 1'b0;
    check("mthi_hi", 64'(hi), 64'h0000_0000_1234_5678);
    check("mthi_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);

    // Second start and MTLO while busy are both ignored.
`ifdef MULDIV_FAST_MUL_EN
    op = 2'd3;
    a = 32'd15;
    b = 32'd1;
`else
    op = 2'd1;
    a = 32'd3;
    b = 32'd5;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    op = 2'd1;
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    we_lo = 1'b1;
    wdata = 32'hDEAD_BEEF;
    tick();
    we_lo = 1'b0;
    check("busy_hi_held", 64'(hi), 64'h0000_0000_1234_5678);
    check("busy_lo_held", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    wait_idle("ignore", DIV_LAT - 11);
    check("ignore_hi", 64'(hi), 64'd0);
    check("ignore_lo", 64'(lo), 64'h0000_0000_0000_000F);
    tick();
    check("ignore_no_restart", 64'(busy), 64'd0);

    // Reset in the middle of a divide.
    op = 2'd3;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    do_op("divu_fresh", 2'd3, 32'd1000, 32'd3, DIV_LAT, 32'h0000_0001, 32'h0000_014D);

    // start and MTHI in the same IDLE cycle: write lands, result overwrites later.
    op = 2'd1;
    a = 32'd2;
    b = 32'd3;
    we_hi = 1'b1;
    wdata = 32'hAAAA_5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    we_hi = 1'b0;
    check("same_cycle_mthi", 64'(hi), 64'h0000_0000_AAAA_5555);
    wait_idle("same_cycle", MUL_LAT);
    check("same_cycle_hi", 64'(hi), 64'd0);
    check("same_cycle_lo", 64'(lo), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
